// File: rtl/rom_reader_pkg.sv
// rom_reader_pkg: FSM encoding, ROM read latency and FIFO sizing shared by rom_reader.
package rom_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  localparam int unsigned RD_LAT     = 1;
  localparam int unsigned FIFO_DEPTH = 2;

  // A new read may go out only if every word already owed to the FIFO still fits,
  // counting the word that leaves on this same edge.
  function automatic logic credit_ok(input logic [1:0] count,
                                     input logic [2:0] inflight,
                                     input logic       pop);
    return ({1'b0, count} + inflight) < (3'(FIFO_DEPTH) + {2'b00, pop});
  endfunction

endpackage

// File: rtl/rom_reader_fifo.sv
// rom_reader_fifo: 2-entry register FIFO; the head entry drives the output directly.
module rom_reader_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   count_q, count_d;

  // pop_i is only ever raised while valid_o is high; push_i never arrives when full.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (count_q == 2'd0) head_d = wdata_i;
        else                 tail_d = wdata_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = wdata_i;
        end else begin
          head_d = tail_q;
          tail_d = wdata_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign rdata_o = head_q;
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/rom_reader.sv
// rom_reader: walks LEN ROM addresses from BASE and streams the words out, credit-limited.
// Define ROM_READER_LAST_EN to add the m_last port, raised with the final beat.
module rom_reader
  import rom_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
`ifdef ROM_READER_LAST_EN
  output logic                  m_last,
`endif
  output state_e                dbg_state_o
);

`ifdef ROM_READER_LAST_EN
  localparam int FW = DATA_WIDTH + 1;
`else
  localparam int FW = DATA_WIDTH;
`endif

  state_e                state_q;
  logic                  busy_q, done_q;
  logic [ADDR_WIDTH-1:0] rom_addr_q;
  logic [ADDR_WIDTH:0]   len_q, issued_q, accepted_q;
  logic [RD_LAT-1:0]     inflight_q;
  logic [ADDR_WIDTH:0]   issued_nxt, accepted_nxt;
  logic [1:0]            fifo_count;
  logic [FW-1:0]         fifo_wdata, fifo_rdata;
  logic                  pop, issue, last_issue, last_pop;

  // Stream: a beat transfers on an edge where m_valid & m_ready; once m_valid rises,
  // m_data and m_valid hold until that transfer happens.
  assign pop          = m_valid & m_ready;
  assign issued_nxt   = issued_q + 1'b1;
  assign accepted_nxt = accepted_q + 1'b1;
  assign issue        = (state_q == ST_ISSUE) &&
                        credit_ok(fifo_count, 3'($countones(inflight_q)), pop);
  assign last_issue   = issue && (issued_nxt == len_q);
  assign last_pop     = pop && (accepted_nxt == len_q);

`ifdef ROM_READER_LAST_EN
  logic [RD_LAT-1:0] tag_q;
  assign fifo_wdata       = {tag_q[RD_LAT-1], rom_q};
  assign {m_last, m_data} = fifo_rdata;
`else
  assign fifo_wdata = rom_q;
  assign m_data     = fifo_rdata;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rom_addr_q <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      inflight_q <= '0;
`ifdef ROM_READER_LAST_EN
      tag_q      <= '0;
`endif
    end else begin
      done_q     <= 1'b0;
      // Shift marks the word whose ROM data lands on the FIFO RD_LAT edges later.
      inflight_q <= RD_LAT'({inflight_q, issue});
`ifdef ROM_READER_LAST_EN
      tag_q      <= RD_LAT'({tag_q, last_issue});
`endif
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q     <= 1'b1;
            rom_addr_q <= base_addr;
            len_q      <= length;
            issued_q   <= '0;
            accepted_q <= '0;
            state_q    <= (length == '0) ? ST_FINISH : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (issue) begin
            rom_addr_q <= rom_addr_q + 1'b1;
            issued_q   <= issued_nxt;
          end
          if (pop) accepted_q <= accepted_nxt;
          if (last_issue) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (pop) accepted_q <= accepted_nxt;
          if (last_pop) state_q <= ST_FINISH;
        end
        ST_FINISH: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  rom_reader_fifo #(.W(FW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q[RD_LAT-1]),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .valid_o (m_valid),
    .count_o (fifo_count)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign rom_addr    = rom_addr_q;
  assign dbg_state_o = state_q;

endmodule
